// File: rtl/register_file_param.sv
// rtl/register_file_param.sv - WIDTH x DEPTH register file, 2 async reads / 1 sync write, busy scoreboard
// Optional write-through forwarding on the read ports: define RF_BYPASS_EN.
module register_file_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              r,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic [ADDR_W-1:0] rd,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              issueEn,
  input  logic [ADDR_W-1:0] issueRd,
  output logic [WIDTH-1:0]  dataA,
  output logic [WIDTH-1:0]  dataB,
  output logic              busyA,
  output logic              busyB,
  output logic              anyBusy
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic write_hit;
  logic issue_hit;

  assign write_hit = writeEn && (rd != '0);
  assign issue_hit = issueEn && (issueRd != '0);

  // Issue is applied after writeback so a same-index collision leaves the entry busy.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (write_hit) begin
        regs[rd] <= dataIn;
        busy[rd] <= 1'b0;
      end
      if (issue_hit) begin
        busy[issueRd] <= 1'b1;
      end
    end
  end

  always_comb begin
    dataA = '0;
    busyA = 1'b0;
    if (rs1 != '0) begin
      dataA = regs[rs1];
      busyA = busy[rs1];
    end
`ifdef RF_BYPASS_EN
    // Forwarding is suppressed during reset so the ports read zero while r is high.
    if (!r && write_hit && (rd == rs1)) begin
      dataA = dataIn;
      busyA = 1'b0;
    end
`endif
  end

  always_comb begin
    dataB = '0;
    busyB = 1'b0;
    if (rs2 != '0) begin
      dataB = regs[rs2];
      busyB = busy[rs2];
    end
`ifdef RF_BYPASS_EN
    if (!r && write_hit && (rd == rs2)) begin
      dataB = dataIn;
      busyB = 1'b0;
    end
`endif
  end

  assign anyBusy = |busy;

endmodule
